// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the execute (A)
// and load/store (B) writeback paths, with a registered write stage and pending mask.
module rf_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [ADDR_W-1:0]    a_addr,
   input  logic [DATA_W-1:0]    a_data,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [ADDR_W-1:0]    b_addr,
   input  logic [DATA_W-1:0]    b_data,
   input  logic                 flush,
   output logic                 rf_en,
   output logic                 rf_we,
   output logic [ADDR_W-1:0]    rf_waddr,
   output logic [DATA_W-1:0]    rf_wdata,
   output logic [2**ADDR_W-1:0] pend_mask,
   output logic [CNT_W-1:0]     wr_count
);

   logic              ptr_b_q, ptr_b_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              grant_a, grant_b;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // Issue stage: ptr_b_q set means B wins the next tie
   always_comb begin
      grant_a = a_valid & (~b_valid | ~ptr_b_q);
      grant_b = b_valid & (~a_valid | ptr_b_q);
      a_ready = grant_a & ~flush & rst_n;
      b_ready = grant_b & ~flush & rst_n;
   end

   always_comb begin
      ptr_b_d = ptr_b_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      cnt_d   = we_q ? sat_inc(cnt_q) : cnt_q;
      // x0 writes are accepted and use their turn but never reach the register file
      if (a_ready) begin
         ptr_b_d = 1'b1;
         if (a_addr != '0) begin
            we_d    = 1'b1;
            waddr_d = a_addr;
            wdata_d = a_data;
         end
      end else if (b_ready) begin
         ptr_b_d = 1'b0;
         if (b_addr != '0) begin
            we_d    = 1'b1;
            waddr_d = b_addr;
            wdata_d = b_data;
         end
      end
   end

   // Write stage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_b_q <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         ptr_b_q <= ptr_b_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      pend_mask = '0;
      if (we_q) pend_mask[waddr_q] = 1'b1;
   end

   assign rf_en    = we_q;
   assign rf_we    = we_q;
   assign rf_waddr = waddr_q;
   assign rf_wdata = wdata_q;
   assign wr_count = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a turn-based reference model checked every cycle,
// plus literal expectations per scenario; a second instance uses a 2-bit counter.
module tb_rf_wb_arbiter;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, a_valid, b_valid, flush;
   logic [ADDR_W-1:0] a_addr, b_addr;
   logic [DATA_W-1:0] a_data, b_data;

   logic              a_ready, b_ready, rf_en, rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [31:0]       pend_mask;
   logic [CNT_W-1:0]  wr_count;

   logic              a_ready2, b_ready2, rf_en2, rf_we2;
   logic [ADDR_W-1:0] rf_waddr2;
   logic [DATA_W-1:0] rf_wdata2;
   logic [31:0]       pend_mask2;
   logic [1:0]        wr_count2;

   rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .flush(flush), .rf_en(rf_en), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .pend_mask(pend_mask), .wr_count(wr_count)
   );

   rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready2), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready2), .b_addr(b_addr), .b_data(b_data),
      .flush(flush), .rf_en(rf_en2), .rf_we(rf_we2), .rf_waddr(rf_waddr2),
      .rf_wdata(rf_wdata2), .pend_mask(pend_mask2), .wr_count(wr_count2)
   );

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   // Reference model: who won last decides ties; expected write slot and write total
   logic              m_last_was_a;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   int                m_cnt;
   logic              exp_ar, exp_br;

   always_comb begin
      exp_ar = 1'b0;
      exp_br = 1'b0;
      if (rst_n && !flush) begin
         if (a_valid && b_valid) begin
            exp_ar = m_last_was_a ? 1'b0 : 1'b1;
            exp_br = m_last_was_a;
         end else begin
            exp_ar = a_valid;
            exp_br = b_valid;
         end
      end
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         m_last_was_a <= 1'b0;
         m_we         <= 1'b0;
         m_addr       <= '0;
         m_data       <= '0;
         m_cnt        <= 0;
      end else begin
         if (m_we) m_cnt <= m_cnt + 1;
         m_we <= 1'b0;
         if (exp_ar) begin
            m_last_was_a <= 1'b1;
            if (a_addr != 0) begin
               m_we <= 1'b1; m_addr <= a_addr; m_data <= a_data;
            end
         end else if (exp_br) begin
            m_last_was_a <= 1'b0;
            if (b_addr != 0) begin
               m_we <= 1'b1; m_addr <= b_addr; m_data <= b_data;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] exp_pend();
      return m_we ? (64'd1 << m_addr) : 64'd0;
   endfunction

   task automatic sample();
      @(negedge clk);
      if (check_en) begin
         chk("model a_ready", 64'(a_ready), 64'(exp_ar));
         chk("model b_ready", 64'(b_ready), 64'(exp_br));
         chk("model rf_we", 64'(rf_we), 64'(m_we));
         chk("model rf_en", 64'(rf_en), 64'(m_we));
         chk("model rf_waddr", 64'(rf_waddr), 64'(m_addr));
         chk("model rf_wdata", 64'(rf_wdata), 64'(m_data));
         chk("model pend_mask", 64'(pend_mask), exp_pend());
         chk("model wr_count", 64'(wr_count), 64'((m_cnt > 65535) ? 65535 : m_cnt));
         chk("model sat a_ready", 64'(a_ready2), 64'(exp_ar));
         chk("model sat b_ready", 64'(b_ready2), 64'(exp_br));
         chk("model sat rf_we", 64'(rf_we2), 64'(m_we));
         chk("model sat rf_en", 64'(rf_en2), 64'(m_we));
         chk("model sat rf_waddr", 64'(rf_waddr2), 64'(m_addr));
         chk("model sat rf_wdata", 64'(rf_wdata2), 64'(m_data));
         chk("model sat pend_mask", 64'(pend_mask2), exp_pend());
         chk("model sat wr_count", 64'(wr_count2), 64'((m_cnt > 3) ? 3 : m_cnt));
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0;
      adv(); adv();
      rst_n = 1'b1;
      check_en = 1'b1;

      // 1. reset then idle
      sample();
      chk("rst rf_we", 64'(rf_we), 64'd0);
      chk("rst rf_waddr", 64'(rf_waddr), 64'd0);
      chk("rst pend_mask", 64'(pend_mask), 64'd0);
      chk("rst wr_count", 64'(wr_count), 64'd0);
      chk("rst readies", 64'({a_ready, b_ready}), 64'd0);
      adv();

      // 2. single A write
      a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
      sample();
      chk("A single a_ready", 64'(a_ready), 64'd1);
      adv();
      a_valid = 1'b0;
      sample();
      chk("A single rf_we", 64'(rf_we), 64'd1);
      chk("A single rf_waddr", 64'(rf_waddr), 64'd5);
      chk("A single rf_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
      chk("A single pend_mask", 64'(pend_mask), 64'h20);
      adv();
      sample();
      chk("A single wr_count", 64'(wr_count), 64'd1);
      chk("A single rf_we off", 64'(rf_we), 64'd0);

      // 4. x0 write from B (also hands the next tie back to A)
      b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1234;
      sample();
      chk("x0 b_ready", 64'(b_ready), 64'd1);
      adv();
      b_valid = 1'b0;
      sample();
      chk("x0 rf_we", 64'(rf_we), 64'd0);
      chk("x0 pend_mask", 64'(pend_mask), 64'd0);
      adv();
      sample();
      chk("x0 wr_count", 64'(wr_count), 64'd1);
      adv();

      // 3. contention: grants A,B,A,B back to back
      a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA1;
      b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hB2;
      sample();
      chk("rr c1 readies", 64'({a_ready, b_ready}), 64'b10);
      adv();
      a_addr = 5'd3; a_data = 32'hA3;
      sample();
      chk("rr c2 readies", 64'({a_ready, b_ready}), 64'b01);
      chk("rr c2 rf_waddr", 64'(rf_waddr), 64'd1);
      adv();
      b_addr = 5'd4; b_data = 32'hB4;
      sample();
      chk("rr c3 readies", 64'({a_ready, b_ready}), 64'b10);
      chk("rr c3 rf_waddr", 64'(rf_waddr), 64'd2);
      chk("rr c3 rf_wdata", 64'(rf_wdata), 64'hB2);
      adv();
      a_valid = 1'b0;
      sample();
      chk("rr c4 readies", 64'({a_ready, b_ready}), 64'b01);
      chk("rr c4 rf_waddr", 64'(rf_waddr), 64'd3);
      chk("rr c4 rf_we", 64'(rf_we), 64'd1);
      adv();
      b_valid = 1'b0;
      sample();
      chk("rr c5 rf_waddr", 64'(rf_waddr), 64'd4);
      chk("rr c5 pend_mask", 64'(pend_mask), 64'h10);
      adv();
      sample();
      chk("rr wr_count", 64'(wr_count), 64'd5);
      chk("sat wr_count", 64'(wr_count2), 64'd3);
      adv();

      // 5. flush: B write accepted just before, then both valid under flush
      b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h77;
      sample();
      chk("fl pre b_ready", 64'(b_ready), 64'd1);
      adv();
      a_valid = 1'b1; a_addr = 5'd9;  a_data = 32'h99;
      b_valid = 1'b1; b_addr = 5'd10; b_data = 32'h1010;
      flush = 1'b1;
      sample();
      chk("fl1 readies", 64'({a_ready, b_ready}), 64'd0);
      chk("fl1 rf_we", 64'(rf_we), 64'd1);
      chk("fl1 rf_waddr", 64'(rf_waddr), 64'd7);
      adv();
      sample();
      chk("fl2 readies", 64'({a_ready, b_ready}), 64'd0);
      chk("fl2 rf_we", 64'(rf_we), 64'd0);
      adv();
      flush = 1'b0;
      sample();
      chk("fl after readies", 64'({a_ready, b_ready}), 64'b10);
      adv();
      a_valid = 1'b0;
      sample();
      chk("fl after2 b_ready", 64'(b_ready), 64'd1);
      chk("fl after2 rf_waddr", 64'(rf_waddr), 64'd9);
      adv();
      b_valid = 1'b0;
      sample();
      chk("fl after3 rf_wdata", 64'(rf_wdata), 64'h1010);
      adv();
      sample();
      chk("fl wr_count", 64'(wr_count), 64'd8);
      adv();

      // 6. reset while a write sits in the output register
      a_valid = 1'b1; a_addr = 5'd11; a_data = 32'hBB;
      sample();
      chk("mr a_ready", 64'(a_ready), 64'd1);
      adv();
      rst_n = 1'b0; b_valid = 1'b1; b_addr = 5'd12;
      sample();
      chk("mr in-reset readies", 64'({a_ready, b_ready}), 64'd0);
      chk("mr in-reset rf_we", 64'(rf_we), 64'd1);
      adv();
      rst_n = 1'b1;
      sample();
      chk("mr rf_we", 64'(rf_we), 64'd0);
      chk("mr pend_mask", 64'(pend_mask), 64'd0);
      chk("mr wr_count", 64'(wr_count), 64'd0);
      chk("mr sat wr_count", 64'(wr_count2), 64'd0);
      chk("mr rf_waddr", 64'(rf_waddr), 64'd0);
      chk("mr tie to A", 64'({a_ready, b_ready}), 64'b10);
      adv();
      a_valid = 1'b0;
      sample();
      chk("mr post rf_waddr", 64'(rf_waddr), 64'd11);
      adv();
      b_valid = 1'b0;
      sample();
      adv();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
